// File: rtl/match_sequencer.sv
// Tic-tac-toe match scheduler: grants board write access to player/CPU in turn,
// scores each finished game, holds the result, and runs games until a side hits WIN_TARGET.
module match_sequencer #(
  parameter int TURN_TIMEOUT = 32,
  parameter int HOLD_CYCLES  = 8,
  parameter int WIN_TARGET   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       player_done_i,
  input  logic       cpu_done_i,
  input  logic       player_win_i,
  input  logic       cpu_win_i,
  input  logic       is_full_i,
  output logic       player_en_o,
  output logic       cpu_en_o,
  output logic       clr_o,
  output logic       first_mover_o,
  output logic [3:0] player_score_o,
  output logic [3:0] cpu_score_o,
  output logic [3:0] draws_o,
  output logic [3:0] timeouts_o,
  output logic       match_over_o,
  output logic [2:0] st_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_PLAYER    = 3'd2,
    S_CPU       = 3'd3,
    S_CHECK     = 3'd4,
    S_HOLD      = 3'd5,
    S_MATCH_END = 3'd6
  } state_t;

  localparam int TW = (TURN_TIMEOUT > 2) ? $clog2(TURN_TIMEOUT) : 1;
  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TURN_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    TARGET     = 4'(WIN_TARGET);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    pscore_q, pscore_d, cscore_q, cscore_d;
  logic [3:0]    draws_q, draws_d, tout_q, tout_d;
  logic          first_q, first_d;
  logic          last_cpu_q, last_cpu_d;
  logic          player_en_q, cpu_en_q, clr_q, match_over_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    hold_d     = '0;
    pscore_d   = pscore_q;
    cscore_d   = cscore_q;
    draws_d    = draws_q;
    tout_d     = tout_q;
    first_d    = first_q;
    last_cpu_d = last_cpu_q;
    case (state_q)
      S_IDLE, S_MATCH_END: begin
        if (start_i) begin
          pscore_d = 4'd0;
          cscore_d = 4'd0;
          draws_d  = 4'd0;
          tout_d   = 4'd0;
          first_d  = 1'b0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: state_d = first_q ? S_CPU : S_PLAYER;
      S_PLAYER: begin
        // A move on the final timer cycle takes precedence over the forfeit.
        if (player_done_i) begin
          last_cpu_d = 1'b0;
          state_d    = S_CHECK;
        end else if (timer_q == TIMER_LAST) begin
          tout_d  = sat_inc(tout_q);
          state_d = S_CPU;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_CPU: begin
        if (cpu_done_i) begin
          last_cpu_d = 1'b1;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (player_win_i) begin
          pscore_d = sat_inc(pscore_q);
          state_d  = S_HOLD;
        end else if (cpu_win_i) begin
          cscore_d = sat_inc(cscore_q);
          state_d  = S_HOLD;
        end else if (is_full_i) begin
          draws_d = sat_inc(draws_q);
          state_d = S_HOLD;
        end else begin
          state_d = last_cpu_q ? S_PLAYER : S_CPU;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          if ((pscore_q == TARGET) || (cscore_q == TARGET)) begin
            state_d = S_MATCH_END;
          end else begin
            first_d = ~first_q;
            state_d = S_CLEAR;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet track st_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      hold_q       <= '0;
      pscore_q     <= 4'd0;
      cscore_q     <= 4'd0;
      draws_q      <= 4'd0;
      tout_q       <= 4'd0;
      first_q      <= 1'b0;
      last_cpu_q   <= 1'b0;
      player_en_q  <= 1'b0;
      cpu_en_q     <= 1'b0;
      clr_q        <= 1'b0;
      match_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      hold_q       <= hold_d;
      pscore_q     <= pscore_d;
      cscore_q     <= cscore_d;
      draws_q      <= draws_d;
      tout_q       <= tout_d;
      first_q      <= first_d;
      last_cpu_q   <= last_cpu_d;
      player_en_q  <= (state_d == S_PLAYER);
      cpu_en_q     <= (state_d == S_CPU);
      clr_q        <= (state_d == S_CLEAR);
      match_over_q <= (state_d == S_MATCH_END);
    end
  end

  assign player_en_o    = player_en_q;
  assign cpu_en_o       = cpu_en_q;
  assign clr_o          = clr_q;
  assign match_over_o   = match_over_q;
  assign first_mover_o  = first_q;
  assign player_score_o = pscore_q;
  assign cpu_score_o    = cscore_q;
  assign draws_o        = draws_q;
  assign timeouts_o     = tout_q;
  assign st_o           = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: a cycle table walks a full match, then
// hand-written sequences cover async reset mid-game.
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, player_done, cpu_done, player_win, cpu_win, is_full;
  logic       player_en, cpu_en, clr, first_mover, match_over;
  logic [3:0] player_score, cpu_score, draws, timeouts;
  logic [2:0] st;

  int n_checks = 0;
  int n_fail   = 0;

  match_sequencer #(.TURN_TIMEOUT(32), .HOLD_CYCLES(8), .WIN_TARGET(3)) dut (
    .clk(clk), .rst(rst), .start_i(start), .player_done_i(player_done),
    .cpu_done_i(cpu_done), .player_win_i(player_win), .cpu_win_i(cpu_win),
    .is_full_i(is_full), .player_en_o(player_en), .cpu_en_o(cpu_en), .clr_o(clr),
    .first_mover_o(first_mover), .player_score_o(player_score),
    .cpu_score_o(cpu_score), .draws_o(draws), .timeouts_o(timeouts),
    .match_over_o(match_over), .st_o(st)
  );

  always #5 clk = ~clk;

  // Packed view: st, player_en, cpu_en, clr, first_mover, match_over, ps, cs, draws, timeouts
  typedef logic [23:0] obs_t;

  typedef struct {
    logic [5:0] in;   // start, player_done, cpu_done, player_win, cpu_win, is_full
    int         rep;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];

  function automatic obs_t pk(input logic [2:0] s, input logic pe, input logic ce,
                              input logic cl, input logic fm, input logic mo,
                              input logic [3:0] ps, input logic [3:0] cs,
                              input logic [3:0] dr, input logic [3:0] to);
    return {s, pe, ce, cl, fm, mo, ps, cs, dr, to};
  endfunction

  function automatic obs_t observe();
    return {st, player_en, cpu_en, clr, first_mover, match_over,
            player_score, cpu_score, draws, timeouts};
  endfunction

  task automatic add(input logic [5:0] in, input int rep, input obs_t exp);
    vec_t v;
    v.in  = in;
    v.rep = rep;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = observe();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] in);
    {start, player_done, cpu_done, player_win, cpu_win, is_full} = in;
  endtask

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] STA  = 6'b100000;
  localparam logic [5:0] PD   = 6'b010000;
  localparam logic [5:0] CD   = 6'b001000;
  localparam logic [5:0] PW   = 6'b000100;
  localparam logic [5:0] CW   = 6'b000010;
  localparam logic [5:0] FL   = 6'b000001;

  initial begin
    // Game 1: player first, player wins on its 3rd move (stray cpu_done ignored).
    add(STA,  1, pk(3'd1,1'b0,1'b0,1'b1,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    add(NONE, 1, pk(3'd2,1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    add(PD,   1, pk(3'd4,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    add(CD,   1, pk(3'd3,1'b0,1'b1,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    add(CD,   1, pk(3'd4,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    add(NONE, 1, pk(3'd2,1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    add(CD,   1, pk(3'd2,1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    add(PD,   1, pk(3'd4,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    add(NONE, 1, pk(3'd3,1'b0,1'b1,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    add(CD,   1, pk(3'd4,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    add(NONE, 1, pk(3'd2,1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    add(PD,   1, pk(3'd4,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    add(PW,   1, pk(3'd5,1'b0,1'b0,1'b0,1'b0,1'b0,4'd1,4'd0,4'd0,4'd0));
    add(NONE, 7, pk(3'd5,1'b0,1'b0,1'b0,1'b0,1'b0,4'd1,4'd0,4'd0,4'd0));
    add(NONE, 1, pk(3'd1,1'b0,1'b0,1'b1,1'b1,1'b0,4'd1,4'd0,4'd0,4'd0));
    add(NONE, 1, pk(3'd3,1'b0,1'b1,1'b0,1'b1,1'b0,4'd1,4'd0,4'd0,4'd0));
    // Game 2: CPU first, draw.
    add(CD,   1, pk(3'd4,1'b0,1'b0,1'b0,1'b1,1'b0,4'd1,4'd0,4'd0,4'd0));
    add(FL,   1, pk(3'd5,1'b0,1'b0,1'b0,1'b1,1'b0,4'd1,4'd0,4'd1,4'd0));
    add(NONE, 8, pk(3'd1,1'b0,1'b0,1'b1,1'b0,1'b0,4'd1,4'd0,4'd1,4'd0));
    add(NONE, 1, pk(3'd2,1'b1,1'b0,1'b0,1'b0,1'b0,4'd1,4'd0,4'd1,4'd0));
    // Game 3: player times out after 32 grant cycles, CPU wins.
    add(NONE,31, pk(3'd2,1'b1,1'b0,1'b0,1'b0,1'b0,4'd1,4'd0,4'd1,4'd0));
    add(NONE, 1, pk(3'd3,1'b0,1'b1,1'b0,1'b0,1'b0,4'd1,4'd0,4'd1,4'd1));
    add(CD,   1, pk(3'd4,1'b0,1'b0,1'b0,1'b0,1'b0,4'd1,4'd0,4'd1,4'd1));
    add(CW,   1, pk(3'd5,1'b0,1'b0,1'b0,1'b0,1'b0,4'd1,4'd1,4'd1,4'd1));
    add(NONE, 8, pk(3'd1,1'b0,1'b0,1'b1,1'b1,1'b0,4'd1,4'd1,4'd1,4'd1));
    add(NONE, 1, pk(3'd3,1'b0,1'b1,1'b0,1'b1,1'b0,4'd1,4'd1,4'd1,4'd1));
    // Game 4: player_done on the timeout cycle, then both wins -> player credited.
    add(CD,   1, pk(3'd4,1'b0,1'b0,1'b0,1'b1,1'b0,4'd1,4'd1,4'd1,4'd1));
    add(NONE, 1, pk(3'd2,1'b1,1'b0,1'b0,1'b1,1'b0,4'd1,4'd1,4'd1,4'd1));
    add(NONE,31, pk(3'd2,1'b1,1'b0,1'b0,1'b1,1'b0,4'd1,4'd1,4'd1,4'd1));
    add(PD,   1, pk(3'd4,1'b0,1'b0,1'b0,1'b1,1'b0,4'd1,4'd1,4'd1,4'd1));
    add(PW|CW,1, pk(3'd5,1'b0,1'b0,1'b0,1'b1,1'b0,4'd2,4'd1,4'd1,4'd1));
    add(NONE, 8, pk(3'd1,1'b0,1'b0,1'b1,1'b0,1'b0,4'd2,4'd1,4'd1,4'd1));
    add(NONE, 1, pk(3'd2,1'b1,1'b0,1'b0,1'b0,1'b0,4'd2,4'd1,4'd1,4'd1));
    // Game 5: CPU wins; start during CHECK is ignored.
    add(PD,   1, pk(3'd4,1'b0,1'b0,1'b0,1'b0,1'b0,4'd2,4'd1,4'd1,4'd1));
    add(STA,  1, pk(3'd3,1'b0,1'b1,1'b0,1'b0,1'b0,4'd2,4'd1,4'd1,4'd1));
    add(CD,   1, pk(3'd4,1'b0,1'b0,1'b0,1'b0,1'b0,4'd2,4'd1,4'd1,4'd1));
    add(CW,   1, pk(3'd5,1'b0,1'b0,1'b0,1'b0,1'b0,4'd2,4'd2,4'd1,4'd1));
    add(NONE, 8, pk(3'd1,1'b0,1'b0,1'b1,1'b1,1'b0,4'd2,4'd2,4'd1,4'd1));
    add(NONE, 1, pk(3'd3,1'b0,1'b1,1'b0,1'b1,1'b0,4'd2,4'd2,4'd1,4'd1));
    // Game 6: CPU reaches 3 -> MATCH_END, then restart.
    add(CD,   1, pk(3'd4,1'b0,1'b0,1'b0,1'b1,1'b0,4'd2,4'd2,4'd1,4'd1));
    add(CW,   1, pk(3'd5,1'b0,1'b0,1'b0,1'b1,1'b0,4'd2,4'd3,4'd1,4'd1));
    add(NONE, 8, pk(3'd6,1'b0,1'b0,1'b0,1'b1,1'b1,4'd2,4'd3,4'd1,4'd1));
    add(PD,   1, pk(3'd6,1'b0,1'b0,1'b0,1'b1,1'b1,4'd2,4'd3,4'd1,4'd1));
    add(STA,  1, pk(3'd1,1'b0,1'b0,1'b1,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    add(NONE, 1, pk(3'd2,1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));

    rst = 1'b1;
    drive(NONE);
    #12;
    check("reset_state", pk(3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_hold", pk(3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in);
      repeat (vecs[i].rep) @(posedge clk);
      #1;
      drive(NONE);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Time out once so there is a nonzero counter, then reset while cpu_en is high.
    repeat (32) @(posedge clk);
    #1;
    check("pre_reset_cpu", pk(3'd3,1'b0,1'b1,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd1));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", pk(3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));
    #1;
    rst = 1'b0;
    drive(CD);
    @(posedge clk); #1;
    drive(NONE);
    check("post_reset_idle", pk(3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,4'd0,4'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/match_sequencer.md
# match_sequencer

Match-level turn scheduler for the tic-tac-toe core. It owns write access to the shared board, granting it alternately to the player and the CPU AI. It evaluates the win and full flags after every move, holds each result for display, then clears the board. It plays consecutive games, alternating the first mover, until one side reaches the target score.

## Interface
Parameters:
- TURN_TIMEOUT, 32: cycles the player may hold the grant before the turn passes to the CPU.
- HOLD_CYCLES, 8: cycles a finished game stays on the board before clearing.
- WIN_TARGET, 3: game wins that end the match; legal range 1–15.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a match from IDLE or MATCH_END.
- player_done  in  1  one-cycle pulse from the board: player move written.
- cpu_done  in  1  one-cycle pulse from the board: CPU move written.
- player_win  in  1  player has three in a row (combinational from board).
- cpu_win  in  1  CPU has three in a row.
- is_full  in  1  all nine cells occupied.
- player_en  out  1  board write grant to the player.
- cpu_en  out  1  board write grant to the CPU AI.
- clr  out  1  one-cycle board clear.
- first_mover  out  1  mover of the current game: 0 = player, 1 = CPU.
- player_score  out  4  games won by the player.
- cpu_score  out  4  games won by the CPU.
- draws  out  4  drawn games.
- timeouts  out  4  player turns forfeited.
- match_over  out  1  high while in MATCH_END.
- st  out  3  state code.

## Operation
State codes: IDLE=0, CLEAR=1, PLAYER=2, CPU=3, CHECK=4, HOLD=5, MATCH_END=6.

- **IDLE**
  - All grants are low.
  - start: zero all counters, set first_mover=0, go to CLEAR.
- **CLEAR**
  - clr=1 for exactly this cycle.
  - Next state is PLAYER if first_mover=0, else CPU.
- **PLAYER**
  - player_en=1; the turn timer counts from 0.
  - player_done: record last=player, go to CHECK.
  - Timer reaches TURN_TIMEOUT−1 without player_done: timeouts+1 (saturating), go to CPU. The board is unchanged, so no CHECK is needed.
  - player_done on the timeout cycle: player_done wins; no timeout is counted.
- **CPU**
  - cpu_en=1.
  - cpu_done: record last=cpu, go to CHECK.
  - No timeout applies in this state.
- **CHECK** (one cycle, both grants low). Priority order:
  - player_win: player_score+1, go to HOLD.
  - else cpu_win: cpu_score+1, go to HOLD.
  - else is_full: draws+1, go to HOLD.
  - else go to the opposite of last (PLAYER or CPU).
- **HOLD**
  - Count HOLD_CYCLES cycles.
  - Then, if player_score or cpu_score equals WIN_TARGET, go to MATCH_END.
  - Otherwise toggle first_mover and go to CLEAR.
- **MATCH_END**
  - match_over=1; scores remain visible.
  - start: zero counters, first_mover=0, go to CLEAR.
- **Event filtering**
  - A done pulse for the side not currently granted is ignored.
  - start outside IDLE and MATCH_END is ignored.
- **Counters**
  - All four counters are 4-bit and saturate at 15.

## Timing
- **Reset** is asynchronous and forces:
  - st=IDLE;
  - all counters = 0;
  - first_mover=0;
  - player_en, cpu_en, clr and match_over all 0.
  - Reset mid-game abandons the game immediately. The board is not cleared until the next CLEAR.
- **Output encoding:** all outputs are registered. Grants are Moore outputs of the state, with no combinational path from the inputs.
- **Done to CHECK:** a done pulse at edge N puts the FSM in CHECK at edge N+1. The win/full flags are sampled during that CHECK cycle. The board updates at the done edge, so the flags are valid by then.
- **Grant handoff:** a move to the next grant takes 2 cycles (done → CHECK → grant). The player and CPU grants are never high in the same cycle.
- **Timeout:** player_en stays high for exactly TURN_TIMEOUT cycles, then cpu_en rises on the next cycle.
- **Result to next game:**
  - The result cycle is CHECK; HOLD_CYCLES cycles of HOLD follow.
  - clr then pulses for one cycle.
  - The next game's first grant follows the clr cycle.
- **Score update:** counter updates are visible on the edge leaving CHECK.

## Test plan
- **Reset:** reset, then start pulse → clr high for 1 cycle, then player_en=1; all scores 0, st=2.
- **Player win:** player wins via player_done pulses with player_win asserted at the 3rd move → player_score=1, HOLD lasts 8 cycles, clr pulses, first game of the new round has first_mover=1 and cpu_en high.
- **Timeout:** no player_done for 32 cycles → timeouts=1, cpu_en rises on cycle 33; a player_done landing on cycle 32 instead → CHECK, timeouts stays 0.
- **Draw:** is_full=1 with no win at CHECK → draws=1; player_win and cpu_win both high → player credited only.
- **Match end:** CPU wins 3 games → match_over=1, st=6, cpu_score=3; start → counters 0, clr pulse, player_en.
- **Async reset mid-game:** assert rst while cpu_en=1 → all outputs are at their reset values before the next clock edge; a stray cpu_done during PLAYER is ignored.
